cpu_bus_ctrl: RTL
=================

# cpu_bus_ctrl

Instruction sequencer for the 8-bit simple CPU datapath. It latches one instruction per `run` pulse and steps the shared 8-bit tri-state bus through a fixed multi-cycle sequence. At each step it asserts the per-register `Rin`/`Rout` strobes of R0–R3, the DIN buffer enable, and the A/G adder registers. Exactly one source drives the bus in any cycle.

## Interface
Parameters:
- `NREG`, 4: number of general registers. Fixed at 4 by the instruction encoding; it is exposed only for port sizing.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset; asynchronous assertion, synchronous deassertion by the system.
- `run` in 1: start request; sampled only in IDLE.
- `instr` in 8: instruction word, latched into internal IR when `run` is accepted.
- `r_in` out NREG: one-hot register write strobes, to the `Rin` of R0..R3.
- `r_out` out NREG: one-hot register output strobes, to the `Rout` of R0..R3.
- `din_out` out 1: DIN buffer output strobe.
- `a_in` out 1: A register write strobe.
- `g_in` out 1: G register write strobe; G captures the adder result.
- `g_out` out 1: G register output strobe.
- `addsub` out 1: 0 = add, 1 = subtract; meaningful only while `g_in`=1.
- `busy` out 1: 1 in any state other than IDLE.
- `done` out 1: single-cycle pulse in the final step of an instruction.

## Operation
Instruction encoding:
- `instr[7:6]` is the opcode.
- `instr[5:4]` is rx, the destination and first operand.
- `instr[3:2]` is ry.
- `instr[1:0]` is ignored.

Opcodes: 00 `mv rx,ry`; 01 `mvi rx,#DIN`; 10 `add rx,ry`; 11 `sub rx,ry`.

Bus convention: every `*_out` strobe leads its bus cycle by one. A source whose out strobe is high in step Sk drives the bus during Sk+1. Registers latch their enable at the clock edge and drop it at the next edge where both `Rin` and `Rout` are low.

State sequence:
- IDLE: `run`=1 latches `instr` into IR and moves to S1. `run`=0 stays in IDLE.
- mv, S1: `r_out[ry]`.
- mv, S2: `r_in[rx]`, `done`. Then IDLE.
- mvi, S1: `din_out`.
- mvi, S2: `r_in[rx]`, `done`. Then IDLE.
- add/sub, S1: `r_out[rx]`.
- add/sub, S2: `a_in`, `r_out[ry]`. The rx driver drops and the ry driver takes the bus.
- add/sub, S3: `g_in`, `addsub`=opcode[0], `g_out`.
- add/sub, S4: `r_in[rx]`, `done`. Then IDLE.

rx == ry is legal: with `add r1,r1`, r1 holds the bus in S2 and S3, and the result is 2·r1.

Outputs are decoded only from the state register and IR, never from inputs.

## Timing
- Reset: state = IDLE, IR = 0, and all outputs 0 immediately and asynchronously.
- Reset mid-instruction aborts the instruction with no `done`. All strobes fall at once, so downstream registers release the bus at their next edge.
- Latency from the accepting edge to `done`: mv/mvi, `done` is high in the 2nd cycle; add/sub, in the 4th cycle.
- `run` is ignored while `busy`=1, including the `done` cycle. The minimum gap between instructions is one IDLE cycle.
- `instr` changes after acceptance do not affect the running instruction.
- `r_in` and `r_out` are each one-hot or zero; at most one `*_out` strobe is high per cycle.
- `busy` is 1 from the S1 cycle through the `done` cycle inclusive.
- `instr[1:0]`=X must not change behaviour.

## Structure
- Shared package/header `cpu_pkg` holds:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`;
  - state encoding `ST_IDLE`, `ST_S1`..`ST_S4`;
  - instruction field bit positions.
- One sub-module, `dec2to4`: 2-to-4 one-hot decoder with enable. It is used twice, for `r_in` and `r_out`.
- The FSM and output decode live in `cpu_bus_ctrl`.

## Test plan
- Reset: assert `rst_n`=0 during S2 of an add. All outputs must be 0 in the same cycle, and the next state after release is IDLE.
- `mvi`: R2 ← 0x5A. Send `instr`=0x60 with DIN=0x5A. Required: `din_out` in S1, `r_in`=0100 in S2, `done` in cycle 2, R2=0x5A.
- `mv`: R0 ← R3 with R3=0x33. Send `instr`=0x0C. Required: `r_out`=1000 in S1, `r_in`=0001 in S2, R0=0x33, and no bus contention (no X on bus).
- `sub`: R1=0x10, R2=0x03. Send `instr`=0xD8. Required: `done` in cycle 4, R1=0x0D, and `addsub`=1 in S3 only.
- `add r1,r1` with R1=0x81. Required: R1=0x02 (mod 256 wrap).
- `run` held high throughout. Required: second `instr` accepted only after one IDLE cycle, and a `instr` change mid-instruction is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the simple-CPU bus sequencer: opcodes, FSM states and
// instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4
    } state_t;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 4;
    localparam int RY_MSB = 3;
    localparam int RY_LSB = 2;

    // IR keeps only instr[OP_MSB:RY_LSB]; the low bits carry no meaning.
    localparam int IR_W = OP_MSB - RY_LSB + 1;

endpackage

// File: rtl/cpu_bus_ctrl_dec2to4.sv
// 2-to-4 one-hot decoder with enable, drives the Rin/Rout strobe groups.
module dec2to4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// Instruction sequencer for the 8-bit simple CPU: latches one instruction per
// run pulse and steps the shared bus through the register/adder strobes.
module cpu_bus_ctrl
    import cpu_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [7:0]      instr,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] r_out,
    output logic            din_out,
    output logic            a_in,
    output logic            g_in,
    output logic            g_out,
    output logic            addsub,
    output logic            busy,
    output logic            done
);

    state_t          state;
    state_t          state_nxt;
    logic [IR_W-1:0] ir;
    logic [1:0]      op;
    logic [1:0]      rx;
    logic [1:0]      ry;
    logic            rin_en;
    logic            rout_en;
    logic [1:0]      rout_sel;
    logic            instr_unused;

    assign instr_unused = ^instr[RY_LSB-1:0];

    assign op = ir[OP_MSB-RY_LSB -: 2];
    assign rx = ir[RX_MSB-RY_LSB -: 2];
    assign ry = ir[RY_MSB-RY_LSB -: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && run) begin
                ir <= instr[OP_MSB:RY_LSB];
            end
        end
    end

    // Outputs depend only on state and IR, so reset clears them immediately.
    always_comb begin
        state_nxt = state;
        rin_en    = 1'b0;
        rout_en   = 1'b0;
        rout_sel  = rx;
        din_out   = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        g_out     = 1'b0;
        addsub    = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_S1;
                end
            end
            ST_S1: begin
                state_nxt = ST_S2;
                case (op)
                    OP_MV: begin
                        rout_en  = 1'b1;
                        rout_sel = ry;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                    end
                    default: begin
                        rout_en  = 1'b1;
                        rout_sel = rx;
                    end
                endcase
            end
            ST_S2: begin
                if (op == OP_MV || op == OP_MVI) begin
                    rin_en    = 1'b1;
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    a_in      = 1'b1;
                    rout_en   = 1'b1;
                    rout_sel  = ry;
                    state_nxt = ST_S3;
                end
            end
            ST_S3: begin
                g_in      = 1'b1;
                g_out     = 1'b1;
                addsub    = (op == OP_SUB);
                state_nxt = ST_S4;
            end
            ST_S4: begin
                rin_en    = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    dec2to4 u_dec_rin (
        .en     (rin_en),
        .sel    (rx),
        .onehot (r_in)
    );

    dec2to4 u_dec_rout (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (r_out)
    );

endmodule
